// File: rtl/scanline_feeder_pkg.sv
// Shared constants and state encoding for the scanline feeder and its pixel FIFO.
package scanline_feeder_pkg;
  localparam int LINE_WIDTH_DEF = 1024;
  localparam int LINE_COUNT_DEF = 768;
  localparam int COLOR_W        = 12;
  localparam int X_W            = 12;
  localparam int Y_W            = 10;

  typedef logic [COLOR_W-1:0] pixel_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;
endpackage

// File: rtl/scanline_feeder_pixel_fifo.sv
// First-word-fall-through pixel FIFO; head word visible combinationally, push/pop same cycle allowed.
// Push is ignored when full and pop is ignored when empty, so callers may drive raw requests.
module pixel_fifo
  import scanline_feeder_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  pixel_t push_data,
  input  logic   pop,
  output pixel_t pop_data,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);

  pixel_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/scanline_feeder.sv
// Drains buffered pixels into a line buffer, one line per lineend rising edge; writes appear one cycle after each pop.
// Upstream stalls only on FIFO full; an empty FIFO simply pauses the fill.
module scanline_feeder
  import scanline_feeder_pkg::*;
#(
  parameter int LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int LINE_COUNT = LINE_COUNT_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               pix_valid_in,
  input  logic [COLOR_W-1:0] pix_data_in,
  output logic               pix_ready_out,
  input  logic               lineend_in,
  output logic [X_W-1:0]     x_out,
  output logic [COLOR_W-1:0] data_out,
  output logic [Y_W-1:0]     line_y_out,
  output logic               busy_out,
  output logic               overrun_out
);
  localparam logic [X_W-1:0] LAST_X = X_W'(LINE_WIDTH - 1);
  localparam logic [Y_W-1:0] LAST_Y = Y_W'(LINE_COUNT - 1);

  state_t         state;
  state_t         state_next;
  logic           lineend_q;
  logic           lineend_rise;
  logic           fifo_full;
  logic           fifo_empty;
  pixel_t         fifo_data;
  logic           pop;
  logic           last_pix;
  logic [X_W-1:0] x_cnt;

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (pix_valid_in),
    .push_data (pix_data_in),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign lineend_rise  = lineend_in && !lineend_q;
  assign pix_ready_out = !fifo_full;
  assign busy_out      = (state == FILL);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    last_pix   = 1'b0;
    unique case (state)
      IDLE: if (lineend_rise) state_next = FILL;
      FILL: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (x_cnt == LAST_X) begin
            last_pix   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lineend_q   <= 1'b0;
      x_cnt       <= '0;
      x_out       <= '0;
      data_out    <= '0;
      line_y_out  <= '0;
      overrun_out <= 1'b0;
    end else begin
      lineend_q   <= lineend_in;
      // A new line-end while filling is only reported; the current line keeps going.
      overrun_out <= lineend_rise && (state == FILL);
      if (state == IDLE && lineend_rise) begin
        x_cnt <= '0;
      end else if (pop) begin
        x_out    <= x_cnt;
        data_out <= fifo_data;
        x_cnt    <= last_pix ? '0 : x_cnt + 1'b1;
        if (last_pix) line_y_out <= (line_y_out == LAST_Y) ? '0 : line_y_out + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_scanline_feeder.sv
// Randomised and directed bench for scanline_feeder with a queue-based reference model checked every cycle.
module tb_scanline_feeder;
  localparam int LW = 1024;
  localparam int LC = 4;
  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid_in;
  logic [11:0] pix_data_in;
  logic        pix_ready_out;
  logic        lineend_in;
  logic [11:0] x_out;
  logic [11:0] data_out;
  logic [9:0]  line_y_out;
  logic        busy_out;
  logic        overrun_out;

  always #5 clk = ~clk;

  scanline_feeder #(.LINE_WIDTH(LW), .LINE_COUNT(LC), .FIFO_DEPTH(FD)) dut (
    .CLK           (clk),
    .RST           (rst),
    .pix_valid_in  (pix_valid_in),
    .pix_data_in   (pix_data_in),
    .pix_ready_out (pix_ready_out),
    .lineend_in    (lineend_in),
    .x_out         (x_out),
    .data_out      (data_out),
    .line_y_out    (line_y_out),
    .busy_out      (busy_out),
    .overrun_out   (overrun_out)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pixel queue plus line bookkeeping, advanced once per clock.
  logic [11:0] m_q[$];
  bit          m_fill, m_le, m_ov, m_acc, m_rise, m_pop;
  int          m_x, m_xo, m_do, m_y;
  int          cyc, first_wr, last_wr;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_q.delete();
      m_fill = 0; m_le = 0; m_ov = 0; m_acc = 0;
      m_x = 0; m_xo = 0; m_do = 0; m_y = 0;
    end else begin
      m_rise = lineend_in && !m_le;
      m_le   = lineend_in;
      m_acc  = pix_valid_in && (m_q.size() < FD);
      m_pop  = m_fill && (m_q.size() != 0);
      m_ov   = m_rise && m_fill;
      if (m_pop) begin
        m_xo = m_x;
        m_do = int'(m_q.pop_front());
        if (m_x == 0) first_wr = cyc;
        if (m_x == LW - 1) begin
          last_wr = cyc;
          m_fill  = 0;
          m_x     = 0;
          m_y     = (m_y + 1) % LC;
        end else begin
          m_x++;
        end
      end else if (!m_fill && m_rise) begin
        m_fill = 1;
        m_x    = 0;
      end
      if (m_acc) m_q.push_back(pix_data_in);
    end
    #1;
    chk("ready",    pix_ready_out, m_q.size() < FD);
    chk("x_out",    x_out,         m_xo);
    chk("data_out", data_out,      m_do);
    chk("line_y",   line_y_out,    m_y);
    chk("busy",     busy_out,      m_fill);
    chk("overrun",  overrun_out,   m_ov);
  end

  // Source modes: 0 idle, 1 every cycle, 2 every other cycle, 3 random valid/data.
  int mode, seq, ov_cnt, acc;
  bit tog;

  task automatic tick();
    @(negedge clk);
    if (m_acc) seq++;
    if (overrun_out) ov_cnt++;
    case (mode)
      0:       pix_valid_in = 1'b0;
      1:       pix_valid_in = 1'b1;
      2:       begin pix_valid_in = tog; tog = !tog; end
      default: pix_valid_in = 1'($urandom_range(0, 1));
    endcase
    pix_data_in = (mode == 3) ? 12'($urandom) : 12'(seq);
  endtask

  task automatic start_line();
    lineend_in = 1'b1;
    tick(); tick();
    lineend_in = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (busy_out && n < bound) begin tick(); n++; end
    chk(name, busy_out, 0);
  endtask

  task automatic wait_x(input string name, input int v, input int bound);
    int n = 0;
    while (x_out !== 12'(v) && n < bound) begin tick(); n++; end
    chk(name, x_out, v);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"},     x_out, 0);
    chk({tag, "_data"},  data_out, 0);
    chk({tag, "_y"},     line_y_out, 0);
    chk({tag, "_busy"},  busy_out, 0);
    chk({tag, "_ovr"},   overrun_out, 0);
    chk({tag, "_ready"}, pix_ready_out, 1);
  endtask

  initial begin
    rst = 1'b1; pix_valid_in = 1'b0; pix_data_in = '0; lineend_in = 1'b0;
    mode = 0; seq = 0; tog = 0; ov_cnt = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_reset_vals("reset");

    // Fill FIFO with no line-end: only 16 of 20 offered pixels get in.
    mode = 1; seq = 0; acc = 0;
    repeat (20) begin tick(); if (m_acc) acc++; end
    chk("full_accepted", acc, 16);
    chk("full_ready_low", pix_ready_out, 0);
    lineend_in = 1'b1;
    tick();
    chk("fill_busy", busy_out, 1);
    chk("ready_before_pop", pix_ready_out, 0);
    tick();
    chk("ready_after_pop", pix_ready_out, 1);
    tick();
    lineend_in = 1'b0;
    wait_idle("line0_timeout", 1200);
    chk("line0_last_x", x_out, LW - 1);
    chk("line0_last_data", data_out, 1023);
    chk("line0_y", line_y_out, 1);
    chk("line0_consecutive", last_wr - first_wr, LW - 1);

    // Second line-end mid-line: single overrun pulse, fill undisturbed.
    mode = 3; ov_cnt = 0;
    start_line();
    wait_x("reach_x500", 500, 4000);
    lineend_in = 1'b1;
    tick(); tick();
    lineend_in = 1'b0;
    wait_idle("line1_timeout", 4000);
    chk("overrun_once", ov_cnt, 1);
    chk("line1_last_x", x_out, LW - 1);
    chk("line1_y", line_y_out, 2);

    repeat (2) begin
      start_line();
      wait_idle("wrap_timeout", 4000);
    end
    chk("y_wrap", line_y_out, 0);

    // Every-other-cycle source from an empty FIFO.
    mode = 0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_reset_vals("reset2");
    start_line();
    chk("half_busy", busy_out, 1);
    mode = 2; seq = 0; tog = 1;
    wait_idle("half_timeout", 2500);
    chk("half_last_x", x_out, LW - 1);
    chk("half_last_data", data_out, 1023);
    chk("half_spacing", last_wr - first_wr, 2 * (LW - 1));
    chk("half_y", line_y_out, 1);

    // Reset in the middle of a line.
    mode = 3;
    start_line();
    wait_x("reach_x300", 300, 2000);
    rst = 1'b1; mode = 0;
    tick();
    chk_reset_vals("midreset");
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_ready", pix_ready_out, 1);
    mode = 1; seq = 100;
    start_line();
    wait_x("restart_x5", 5, 100);
    chk("restart_data", data_out, 105);
    wait_idle("final_timeout", 2000);
    chk("final_y", line_y_out, 1);

    mode = 0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
